// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control path: FSM states, opcodes,
// ALU function codes and datapath mux select values.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends on the opcode only, never on the FSM state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_SW:   imm = IMM_S;
            OP_BEQ:  imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU function decode, shared with the single-cycle core:
// maps ALUOp plus instruction fields to the 3-bit ALUControl code.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 distinguishes R-type sub from addi with imm[10] set
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main Moore control FSM of the multi-cycle RISC-V core: sequences the shared
// ALU and drives all mux selects and write enables per instruction phase.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter bit HOLD_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       IllegalInstr,
    output logic [3:0] StateOut
);

    state_t     state_q, state_d;
    state_t     cur_state;
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       mem_write_raw;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTER;
                    OP_ITYPE:     state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = ILLEGAL;
                endcase
            end
            MEMADR: begin
                if (op == OP_LW)
                    state_d = MEMREAD;
                else if (op == OP_SW)
                    state_d = MEMWRITE;
                else
                    state_d = FETCH;
            end
            MEMREAD:  state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            JAL:      state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            ILLEGAL:  state_d = HOLD_ON_ILLEGAL ? ILLEGAL : FETCH;
            default:  state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= FETCH;
        else
            state_q <= state_d;
    end

    // During reset the outputs present the FETCH decode so the datapath muxes
    // are already steered for the first fetch when reset drops.
    assign cur_state = reset ? FETCH : state_q;

    always_comb begin
        AdrSrc        = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_REG;
        alu_op        = ALUOP_ADD;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        IllegalInstr  = 1'b0;
        case (cur_state)
            FETCH: begin
                ir_write_raw = 1'b1;
                ALUSrcA      = SRCA_PC;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                pc_update    = 1'b1;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD: begin
                ResultSrc = RES_ALUOUT;
                AdrSrc    = 1'b1;
            end
            MEMWB: begin
                ResultSrc     = RES_DATA;
                reg_write_raw = 1'b1;
            end
            MEMWRITE: begin
                ResultSrc     = RES_ALUOUT;
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_REG;
                alu_op  = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            ALUWB: begin
                ResultSrc     = RES_ALUOUT;
                reg_write_raw = 1'b1;
            end
            BEQ: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_REG;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            ILLEGAL: IllegalInstr = 1'b1;
            default: ;
        endcase
    end

    // Zero feeds PCWrite combinationally so beq resolves within its own cycle.
    assign PCWrite  = (pc_update | (branch & Zero)) & ~reset;
    assign IRWrite  = ir_write_raw & ~reset;
    assign RegWrite = reg_write_raw & ~reset;
    assign MemWrite = mem_write_raw & ~reset;
    assign ImmSrc   = imm_src_of(op);
    assign StateOut = cur_state;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RISC-V core, replacing the single-cycle combinational control.
- Sequences one shared ALU across several cycles per instruction by driving the ALU operand mux selects (ALUSrcA/ALUSrcB), the ALU function, and all write enables.
- Supports lw, sw, R-type, I-type ALU, beq and jal.
- Sits between the instruction register and the datapath muxes and enables.

Parameters:
- HOLD_ON_ILLEGAL, 0, 1 = remain in ILLEGAL until reset; 0 = return to FETCH after one cycle.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- op  input  7  opcode from instruction register
- funct3  input  3  instruction bits 14:12
- funct7b5  input  1  instruction bit 30
- Zero  input  1  ALU zero flag
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register enable
- RegWrite  output  1  register file write enable
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  output  2  ALU B select: 00 = register operand, 01 = ImmExt, 10 = constant 4
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  output  2  immediate format: I = 00, S = 01, B = 10, J = 11
- IllegalInstr  output  1  high while in ILLEGAL
- StateOut  output  4  current state encoding, for debug

Behaviour:
- Moore FSM with one registered state. Unlisted outputs are 0 in every state.
- On a reset-high edge: state <= FETCH.
- While reset is high: PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. The other outputs follow FETCH decode.
- Reset mid-instruction aborts the instruction; FETCH follows the next edge with reset low.

Per-state outputs:
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target precompute).
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: ResultSrc=00, AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- ILLEGAL: IllegalInstr=1.

Derived signals:
- PCWrite = PCUpdate | (Branch & Zero), combinational on Zero in BEQ.

Transitions:
- FETCH -> DECODE.
- DECODE by op:
  - 0000011 (lw) / 0100011 (sw) -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other op -> ILLEGAL
- MEMADR -> MEMREAD if lw, MEMWRITE if sw.
- MEMREAD -> MEMWB -> FETCH.
- MEMWRITE -> FETCH.
- EXECUTER / EXECUTEI / JAL -> ALUWB -> FETCH.
- BEQ -> FETCH.
- ILLEGAL -> FETCH, or self when HOLD_ON_ILLEGAL=1.
- Unused state encodings -> FETCH.

Cycle counts:
- lw 5; sw 4; R-type 4; I-type 4; jal 4; beq 3.

ALU decode (combinational):
- ALUOp 00 -> add; ALUOp 01 -> sub.
- ALUOp 10 by funct3:
  - 000: sub if op[5] & funct7b5, else add
  - 010: slt
  - 110: or
  - 111: and
  - other: add
- ImmSrc is decoded from op alone, independent of state:
  - lw / I-type -> 00
  - sw -> 01
  - beq -> 10
  - jal -> 11
  - other -> 00
- op, funct3 and funct7b5 are stable from DECODE until the next FETCH, since IR loads only in FETCH.

Decomposition:
- Package ctrl_pkg holds:
  - state enum, 4-bit: FETCH=0, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ILLEGAL
  - opcode constants
  - ALUControl codes
  - ALUSrcA / ALUSrcB / ResultSrc select constants
- Sub-module alu_decoder: combinational ALUOp/funct3/funct7b5/op5 -> ALUControl, reused from the single-cycle core.

Test Plan:
- Reset held 3 cycles with op=0110011: StateOut=0 and all enables 0 throughout. First cycle after release: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
- lw (op=0000011): StateOut sequence 0,1,2,3,4,0. RegWrite=1 and ResultSrc=01 only in MEMWB; AdrSrc=1 in MEMREAD; ImmSrc=00.
- R-type sub (funct3=000, funct7b5=1): in EXECUTER, ALUControl=001, ALUSrcA=10, ALUSrcB=00. Repeat with funct3=111 -> 010 and funct3=010 -> 101. 4 cycles each.
- beq: Zero=1 in BEQ -> PCWrite=1; Zero=0 -> PCWrite=0. ALUControl=001, ImmSrc=10, back to FETCH after 3 cycles.
- sw (op=0100011): MEMWRITE has MemWrite=1, AdrSrc=1, RegWrite=0; ImmSrc=01; 4 cycles. jal: JAL has PCWrite=1, ALUSrcA=01, ALUSrcB=10, then ALUWB with RegWrite=1.
- op=1111111: IllegalInstr=1 for one cycle, then FETCH. With HOLD_ON_ILLEGAL=1, stays in ILLEGAL for 10 cycles until reset. Reset pulsed during MEMREAD of lw: no MEMWB/RegWrite occurs, FETCH follows.
